// File: rtl/intpol2_iq_stream_out.sv
// -----------------------------------------------------------------------------
// intpol2_iq_stream_out
//
// Drain stage of the quadratic IQ interpolator. Pops I/Q pairs from the output
// FIFO pair through a shared read enable and presents each pair as one packed
// {Q,I} word on a valid/ready stream. A frame carries a programmable number of
// words; the final word is flagged with o_m_last and followed by a one-cycle
// o_done pulse. A frame length of 0 streams continuously.
//
// A 2-entry skid buffer absorbs the one-cycle FIFO read latency. The word of
// an in-flight read is shown on the stream in the cycle its data arrives; if
// the consumer does not take it, it is parked in the buffer. This keeps one
// word per cycle in steady state with at most two words issued but not taken.
//
// Ports
//   i_clk        clock, rising edge
//   i_rstn       asynchronous active-low reset
//   i_start      1-cycle pulse, begins a frame (only honoured in IDLE)
//   i_abort      return to IDLE next cycle, discard held and in-flight data
//   i_frame_len  words per frame, sampled on i_start; 0 = continuous
//   i_empty      OR of the I/Q output-FIFO empty flags
//   i_fifo_i     I sample from FIFO, valid the cycle after o_re_fifo
//   i_fifo_q     Q sample from FIFO, valid the cycle after o_re_fifo
//   o_re_fifo    read enable to both output FIFOs
//   o_m_data     packed stream word {Q, I}
//   o_m_valid    stream word valid
//   i_m_ready    consumer ready; a word is taken on o_m_valid & i_m_ready
//   o_m_last     final word of a non-continuous frame
//   o_done       1-cycle pulse after the final word was taken
//   o_busy       frame in progress (RUN or DRAIN)
//   o_count      words taken in the current frame, wraps
// -----------------------------------------------------------------------------
module intpol2_iq_stream_out #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [LEN_WIDTH-1:0]    i_frame_len,
    input  logic                    i_empty,
    input  logic [DATA_WIDTH-1:0]   i_fifo_i,
    input  logic [DATA_WIDTH-1:0]   i_fifo_q,
    output logic                    o_re_fifo,
    output logic [2*DATA_WIDTH-1:0] o_m_data,
    output logic                    o_m_valid,
    input  logic                    i_m_ready,
    output logic                    o_m_last,
    output logic                    o_done,
    output logic                    o_busy,
    output logic [LEN_WIDTH-1:0]    o_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    r_issued;
    logic [LEN_WIDTH-1:0]    r_count;
    logic                    r_inflight;
    logic [1:0]              r_occ;
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;

    logic                    w_len_zero;
    logic                    w_issue_ok;
    logic                    w_credit;
    logic                    w_re;
    logic                    w_buf_nonempty;
    logic                    w_valid;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_start_ok;
    logic [2*DATA_WIDTH-1:0] w_fifo_word;
    logic [2*DATA_WIDTH-1:0] w_buf_head;

    assign w_fifo_word    = {i_fifo_q, i_fifo_i};
    assign w_len_zero     = (r_len == '0);
    assign w_issue_ok     = w_len_zero || (r_issued < r_len);
    // Held words plus the outstanding read may never exceed the buffer depth.
    assign w_credit       = ((r_occ + {1'b0, r_inflight}) < 2'd2);
    assign w_re           = (r_state == S_RUN) && !i_empty && !i_abort && w_credit && w_issue_ok;

    assign w_buf_nonempty = (r_occ != 2'd0);
    assign w_valid        = w_buf_nonempty || r_inflight;
    assign w_accept       = w_valid && i_m_ready;
    assign w_last         = w_valid && !w_len_zero && (r_count == (r_len - LEN_WIDTH'(1)));
    // Arriving data goes into the buffer unless it was taken straight off the bus.
    assign w_push         = r_inflight && !(w_accept && !w_buf_nonempty);
    assign w_pop          = w_accept && w_buf_nonempty;
    assign w_start_ok     = (r_state == S_IDLE) && i_start && !i_abort;

    // Skid buffer storage: data registers only, their content is qualified by r_occ.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            logic [2*DATA_WIDTH-1:0] r_entry;
            always_ff @(posedge i_clk) begin
                if (w_push && !i_abort && (r_wr_ptr == 1'(gi))) begin
                    r_entry <= w_fifo_word;
                end
            end
        end
    endgenerate

    assign w_buf_head = r_rd_ptr ? g_buf[1].r_entry : g_buf[0].r_entry;

    // Older buffered word has priority; otherwise show the arriving FIFO word.
    always_comb begin
        o_m_data = '0;
        if (w_buf_nonempty) begin
            o_m_data = w_buf_head;
        end else if (r_inflight) begin
            o_m_data = w_fifo_word;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Leave RUN as the final read is issued so its word is drained in DRAIN.
                if (w_re && !w_len_zero && ((r_issued + LEN_WIDTH'(1)) == r_len)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_accept && w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (i_abort) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (i_abort) begin
                r_inflight <= 1'b0;
                r_occ      <= 2'd0;
                r_wr_ptr   <= 1'b0;
                r_rd_ptr   <= 1'b0;
            end else begin
                r_inflight <= w_re;
                r_occ      <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
                if (w_push) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end

            if (w_start_ok) begin
                r_len    <= i_frame_len;
                r_issued <= '0;
                r_count  <= '0;
            end else begin
                if (w_re) begin
                    r_issued <= r_issued + LEN_WIDTH'(1);
                end
                if (w_accept) begin
                    r_count <= r_count + LEN_WIDTH'(1);
                end
            end
        end
    end

    assign o_re_fifo = w_re;
    assign o_m_valid = w_valid;
    assign o_m_last  = w_last;
    assign o_done    = (r_state == S_DONE);
    assign o_busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_count   = r_count;

endmodule

// File: tb/tb_intpol2_iq_stream_out.sv
// -----------------------------------------------------------------------------
// Bench for intpol2_iq_stream_out. A queue stands in for the output FIFO pair;
// a frame-level reference model tracks which words were read but not yet taken,
// the running word count and the frame phase, and every cycle is compared
// against it. Scenario tasks add exact-timing checks of their own.
// -----------------------------------------------------------------------------
module tb_intpol2_iq_stream_out;

    localparam int DW = 16;
    localparam int LW = 16;

    typedef enum int {P_IDLE, P_RUN, P_DONE} phase_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          abort;
    logic [LW-1:0] frame_len;
    logic          fifo_empty;
    logic [DW-1:0] fifo_i;
    logic [DW-1:0] fifo_q;
    logic          re_fifo;
    logic [2*DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          done;
    logic          busy;
    logic [LW-1:0] count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Environment and reference model
    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    logic        force_empty;
    phase_t      phase;
    logic [LW-1:0] m_len;
    logic [LW-1:0] m_acc;
    int          m_issued;

    // Values sampled in the most recent cycle
    logic        s_re, s_valid, s_last, s_done, s_busy;
    logic [31:0] s_data;
    logic [LW-1:0] s_count;

    always #5 clk = ~clk;

    intpol2_iq_stream_out #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .i_abort     (abort),
        .i_frame_len (frame_len),
        .i_empty     (fifo_empty),
        .i_fifo_i    (fifo_i),
        .i_fifo_q    (fifo_q),
        .o_re_fifo   (re_fifo),
        .o_m_data    (m_data),
        .o_m_valid   (m_valid),
        .i_m_ready   (m_ready),
        .o_m_last    (m_last),
        .o_done      (done),
        .o_busy      (busy),
        .o_count     (count)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    function automatic void upd_empty();
        fifo_empty = force_empty || (src_q.size() == 0);
    endfunction

    function automatic void reset_model();
        src_q.delete();
        exp_q.delete();
        phase       = P_IDLE;
        m_len       = '0;
        m_acc       = '0;
        m_issued    = 0;
        force_empty = 1'b0;
        upd_empty();
    endfunction

    function automatic void preload(input int n, input bit ramp);
        for (int k = 1; k <= n; k++) begin
            if (ramp) src_q.push_back({16'(-k), 16'(k)});
            else      src_q.push_back($urandom());
        end
        upd_empty();
    endfunction

    // One clock: sample at the falling edge, compare with the model, then let
    // the FIFO and the model react to the rising edge.
    task automatic clock_cycle();
        logic        acc;
        logic        exp_last;
        logic [31:0] w;
        int          qsz;
        phase_t      prev;
        @(negedge clk);
        s_re    = re_fifo;
        s_valid = m_valid;
        s_data  = m_data;
        s_last  = m_last;
        s_done  = done;
        s_busy  = busy;
        s_count = count;
        qsz     = exp_q.size();
        exp_last = (m_len != 0) && (m_acc == m_len - 16'd1);

        checks++;
        if (s_re && fifo_empty) begin
            errors++;
            $display("FAIL re_when_empty cyc=%0d re=%b required 0 while empty", cyc, s_re);
        end
        checks++;
        if (s_re && m_len != 0 && m_issued >= int'(m_len)) begin
            errors++;
            $display("FAIL re_over_len cyc=%0d issued=%0d len=%0d", cyc, m_issued, m_len);
        end
        checks++;
        if (qsz + (s_re ? 1 : 0) > 2) begin
            errors++;
            $display("FAIL outstanding cyc=%0d got %0d required <=2", cyc, qsz + (s_re ? 1 : 0));
        end
        checks++;
        if (s_valid !== (qsz != 0)) begin
            errors++;
            $display("FAIL valid cyc=%0d got %b required %b", cyc, s_valid, (qsz != 0));
        end
        if (s_valid && qsz != 0) begin
            checks++;
            if (s_data !== exp_q[0]) begin
                errors++;
                $display("FAIL data cyc=%0d got %08h required %08h", cyc, s_data, exp_q[0]);
            end
            checks++;
            if (s_last !== exp_last) begin
                errors++;
                $display("FAIL last cyc=%0d got %b required %b", cyc, s_last, exp_last);
            end
        end else begin
            checks++;
            if (s_last !== 1'b0) begin
                errors++;
                $display("FAIL last_idle cyc=%0d got %b required 0", cyc, s_last);
            end
        end
        checks++;
        if (s_done !== (phase == P_DONE)) begin
            errors++;
            $display("FAIL done cyc=%0d got %b required %b", cyc, s_done, (phase == P_DONE));
        end
        checks++;
        if (s_busy !== (phase == P_RUN)) begin
            errors++;
            $display("FAIL busy cyc=%0d got %b required %b", cyc, s_busy, (phase == P_RUN));
        end
        checks++;
        if (s_count !== m_acc) begin
            errors++;
            $display("FAIL count cyc=%0d got %0d required %0d", cyc, s_count, m_acc);
        end

        acc = s_valid && m_ready;
        if (acc) $display("ACC cyc=%0d data=%08h count=%0d last=%b", cyc, s_data, s_count, s_last);

        @(posedge clk);
        #1;
        prev = phase;
        if (s_re && src_q.size() != 0) begin
            w = src_q.pop_front();
            fifo_i = w[15:0];
            fifo_q = w[31:16];
            exp_q.push_back(w);
        end
        if (s_re) m_issued++;
        if (prev == P_DONE) phase = P_IDLE;
        if (acc && qsz != 0) begin
            w = exp_q.pop_front();
            m_acc = m_acc + 16'd1;
            if (exp_last && prev == P_RUN) phase = P_DONE;
        end
        if (abort) begin
            phase = P_IDLE;
            exp_q.delete();
        end else if (prev == P_IDLE && start) begin
            phase    = P_RUN;
            m_len    = frame_len;
            m_acc    = '0;
            m_issued = 0;
        end
        upd_empty();
        cyc++;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({re_fifo, m_valid, m_last, done, busy} !== 5'b0 || m_data !== 32'h0 || count !== 16'h0) begin
            errors++;
            $display("FAIL reset_initial re=%b v=%b l=%b d=%b b=%b data=%08h cnt=%0d required all 0",
                     re_fifo, m_valid, m_last, done, busy, m_data, count);
        end
        @(negedge clk);
        rstn = 1'b1;
        reset_model();
        repeat (2) clock_cycle();
        // Mid-RUN reset with words held
        preload(10, 1'b0);
        frame_len = 16'd10;
        m_ready   = 1'b1;
        start     = 1'b1;
        clock_cycle();
        start = 1'b0;
        repeat (3) clock_cycle();
        m_ready = 1'b0;
        repeat (2) clock_cycle();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (re_fifo !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_stream re=%b valid=%b last=%b required 0", re_fifo, m_valid, m_last);
        end
        checks++;
        if (m_data !== 32'h0 || count !== 16'h0) begin
            errors++;
            $display("FAIL reset_async_data data=%08h count=%0d required 0", m_data, count);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_ctl done=%b busy=%b required 0", done, busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        reset_model();
        repeat (3) clock_cycle();
    endtask

    // Frame of 4 ramp pairs, consumer always ready: exact cycle positions.
    task automatic test_frame4();
        logic [31:0] ew;
        preload(4, 1'b1);
        frame_len = 16'd4;
        m_ready   = 1'b1;
        start     = 1'b1;
        clock_cycle();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            clock_cycle();
            ew = {16'(-(c - 1)), 16'(c - 1)};
            checks++;
            if (s_re !== (c <= 4)) begin
                errors++;
                $display("FAIL t2_re c=%0d got %b required %b", c, s_re, (c <= 4));
            end
            checks++;
            if (s_valid !== (c >= 2 && c <= 5)) begin
                errors++;
                $display("FAIL t2_valid c=%0d got %b required %b", c, s_valid, (c >= 2 && c <= 5));
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (s_data !== ew) begin
                    errors++;
                    $display("FAIL t2_data c=%0d got %08h required %08h", c, s_data, ew);
                end
            end
            checks++;
            if (s_last !== (c == 5) || s_done !== (c == 6)) begin
                errors++;
                $display("FAIL t2_last_done c=%0d got last=%b done=%b required %b %b",
                         c, s_last, s_done, (c == 5), (c == 6));
            end
        end
    endtask

    task automatic test_backpressure();
        int dn = 0;
        int n  = 0;
        preload(8, 1'b0);
        frame_len = 16'd8;
        m_ready   = 1'b0;
        start     = 1'b1;
        clock_cycle();
        start = 1'b0;
        while (phase != P_IDLE && n < 60) begin
            m_ready = ~m_ready;
            if (n == 5) begin
                start     = 1'b1;   // must be ignored mid-frame
                frame_len = 16'd3;
            end
            clock_cycle();
            start = 1'b0;
            if (s_done) dn++;
            n++;
        end
        checks++;
        if (phase != P_IDLE) begin
            errors++;
            $display("FAIL t3_timeout frame not finished in %0d cycles", n);
        end
        checks++;
        if (dn != 1 || count !== 16'd8) begin
            errors++;
            $display("FAIL t3_end done_pulses=%0d count=%0d required 1 and 8", dn, count);
        end
    endtask

    task automatic test_empty_pause();
        int res = 0;
        int dn  = 0;
        int n   = 0;
        preload(6, 1'b0);
        frame_len = 16'd6;
        m_ready   = 1'b1;
        start     = 1'b1;
        clock_cycle();
        start = 1'b0;
        while (res < 3 && n < 20) begin
            clock_cycle();
            if (s_re) res++;
            n++;
        end
        force_empty = 1'b1;
        upd_empty();
        repeat (5) begin
            clock_cycle();
            checks++;
            if (s_re !== 1'b0) begin
                errors++;
                $display("FAIL t4_re_paused cyc=%0d got %b required 0", cyc, s_re);
            end
            if (s_done) dn++;
        end
        force_empty = 1'b0;
        upd_empty();
        n = 0;
        while (phase != P_IDLE && n < 40) begin
            clock_cycle();
            if (s_done) dn++;
            n++;
        end
        checks++;
        if (dn != 1 || count !== 16'd6) begin
            errors++;
            $display("FAIL t4_end done_pulses=%0d count=%0d required 1 and 6", dn, count);
        end
    endtask

    task automatic test_continuous();
        int dn = 0;
        int ln = 0;
        preload(40, 1'b0);
        frame_len = 16'd0;
        m_ready   = 1'b1;
        start     = 1'b1;
        clock_cycle();
        start = 1'b0;
        repeat (50) begin
            clock_cycle();
            if (s_done) dn++;
            if (s_last) ln++;
        end
        checks++;
        if (count !== 16'd40 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_stream count=%0d busy=%b required 40 and 1", count, busy);
        end
        checks++;
        if (dn != 0 || ln != 0) begin
            errors++;
            $display("FAIL t5_flags done_pulses=%0d last_words=%0d required 0 and 0", dn, ln);
        end
        abort = 1'b1;
        clock_cycle();
        abort = 1'b0;
        clock_cycle();
    endtask

    task automatic test_abort();
        int n  = 0;
        int dn = 0;
        preload(8, 1'b0);
        frame_len = 16'd8;
        m_ready   = 1'b1;
        start     = 1'b1;
        clock_cycle();
        start = 1'b0;
        while (m_acc < 16'd3 && n < 20) begin
            clock_cycle();
            n++;
        end
        // Steady state here: a read would be issued this cycle
        abort   = 1'b1;
        m_ready = 1'b0;
        clock_cycle();
        abort = 1'b0;
        checks++;
        if (s_re !== 1'b0 || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL t6_abort_cycle re=%b valid=%b required 0 and 1", s_re, s_valid);
        end
        clock_cycle();
        checks++;
        if (s_valid !== 1'b0 || s_done !== 1'b0 || s_count !== 16'd3) begin
            errors++;
            $display("FAIL t6_after valid=%b done=%b count=%0d required 0 0 3", s_valid, s_done, s_count);
        end
        repeat (3) clock_cycle();
        frame_len = 16'd3;
        m_ready   = 1'b1;
        start     = 1'b1;
        clock_cycle();
        start = 1'b0;
        n = 0;
        while (phase != P_IDLE && n < 30) begin
            clock_cycle();
            if (s_done) dn++;
            n++;
        end
        checks++;
        if (dn != 1 || count !== 16'd3) begin
            errors++;
            $display("FAIL t6_restart done_pulses=%0d count=%0d required 1 and 3", dn, count);
        end
    endtask

    task automatic test_random_frames();
        int len;
        int dn;
        int n;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(1, 12);
            preload(len + $urandom_range(0, 2), 1'b0);
            frame_len = 16'(len);
            m_ready   = 1'b1;
            start     = 1'b1;
            clock_cycle();
            start = 1'b0;
            dn = 0;
            n  = 0;
            while (phase != P_IDLE && n < 300) begin
                m_ready     = ($urandom_range(0, 3) != 0);
                force_empty = ($urandom_range(0, 5) == 0);
                upd_empty();
                if ($urandom_range(0, 15) == 0) begin
                    start     = 1'b1;
                    frame_len = 16'd5;
                end
                clock_cycle();
                start = 1'b0;
                if (s_done) dn++;
                n++;
            end
            force_empty = 1'b0;
            upd_empty();
            checks++;
            if (phase != P_IDLE || dn != 1) begin
                errors++;
                $display("FAIL rnd_frame f=%0d len=%0d done_pulses=%0d required 1", f, len, dn);
            end
            checks++;
            if (count !== 16'(len)) begin
                errors++;
                $display("FAIL rnd_count f=%0d got %0d required %0d", f, count, len);
            end
            clock_cycle();
        end
    endtask

    initial begin
        rstn        = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        frame_len   = '0;
        m_ready     = 1'b0;
        fifo_i      = '0;
        fifo_q      = '0;
        force_empty = 1'b0;
        reset_model();
        test_reset();
        test_frame4();
        test_backpressure();
        test_empty_pause();
        test_continuous();
        test_abort();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
